// File: rtl/onehot_to_thermo.sv
// onehot_to_thermo: registers a 16-bit one-hot level code as a 15-bit
// thermometer code plus binary level, behind a one-deep valid/ready stage.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; onehot sampled on acceptance
//   out_valid/out_ready output handshake; thermo/level/out_err held
//   out_err           held word came from a zero or multi-hot code
//   err_sticky        illegal code accepted since reset or clr_err
//   clr_err           synchronous clear of err_sticky (and err_cnt)
//   err_cnt           saturating illegal count, only with ONEHOT_ERR_CNT_EN
//
// Build option: define ONEHOT_ERR_CNT_EN to add the err_cnt port/counter.

module onehot_to_thermo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] onehot,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] thermo,
    output logic [3:0]  level,
    output logic        out_err,
    output logic        err_sticky,
`ifdef ONEHOT_ERR_CNT_EN
    input  logic        clr_err,
    output logic [7:0]  err_cnt
`else
    input  logic        clr_err
`endif
);

    logic        accept;
    logic [3:0]  enc_level;
    logic [14:0] enc_thermo;
    logic        enc_err;
    logic        bad_accept;

    // The stage can take a new word when empty or when the held word
    // leaves on this same edge, giving one word per cycle.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign bad_accept = accept && enc_err;

    // Highest set bit wins, so multi-hot codes still map to a level.
    always_comb begin
        enc_level = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) begin
                enc_level = 4'(i);
            end
        end
    end

    always_comb begin
        enc_thermo = '0;
        for (int i = 0; i < 15; i++) begin
            enc_thermo[i] = (4'(i) < enc_level);
        end
    end

    // Illegal when empty or when more than one bit is set.
    assign enc_err = (onehot == 16'h0000) ||
                     ((onehot & (onehot - 16'd1)) != 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thermo  <= '0;
            level   <= '0;
            out_err <= 1'b0;
        end else if (accept) begin
            thermo  <= enc_thermo;
            level   <= enc_level;
            out_err <= enc_err;
        end
    end

    // Setting takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (bad_accept) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef ONEHOT_ERR_CNT_EN
    // Clear restarts counting, so a same-cycle illegal word counts as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (clr_err) begin
            err_cnt <= bad_accept ? 8'h01 : 8'h00;
        end else if (bad_accept && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_to_thermo.sv
// tb_onehot_to_thermo: directed vectors with hand-computed expectations
// for onehot_to_thermo.

module tb_onehot_to_thermo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] onehot;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] thermo;
    logic [3:0]  level;
    logic        out_err;
    logic        err_sticky;
    logic        clr_err;
`ifdef ONEHOT_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int total;
    int bad;

    onehot_to_thermo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .onehot     (onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .thermo     (thermo),
        .level      (level),
        .out_err    (out_err),
        .err_sticky (err_sticky),
`ifdef ONEHOT_ERR_CNT_EN
        .clr_err    (clr_err),
        .err_cnt    (err_cnt)
`else
        .clr_err    (clr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        onehot    = 16'h0000;
        clr_err   = 1'b0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_thermo", 32'(thermo), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // sweep of legal codes, full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            onehot = 16'd1 << k;
            step();
            chk($sformatf("sw_valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("sw_thermo%0d", k), 32'(thermo),
                (32'd1 << k) - 32'd1);
            chk($sformatf("sw_level%0d", k), 32'(level), 32'(k));
            chk($sformatf("sw_err%0d", k), 32'(out_err), 32'd0);
        end
        chk("sw_k15", 32'(thermo), 32'h7FFF);
        chk("sw_sticky", 32'(err_sticky), 32'd0);

        // illegal codes
        onehot = 16'h0000;
        step();
        chk("zero_thermo", 32'(thermo), 32'd0);
        chk("zero_level", 32'(level), 32'd0);
        chk("zero_err", 32'(out_err), 32'd1);
        chk("zero_sticky", 32'(err_sticky), 32'd1);
        onehot = 16'h0104;
        step();
        chk("mh_level", 32'(level), 32'd8);
        chk("mh_thermo", 32'(thermo), 32'h00FF);
        chk("mh_err", 32'(out_err), 32'd1);
        onehot = 16'h8001;
        step();
        chk("mh15_level", 32'(level), 32'd15);
        chk("mh15_thermo", 32'(thermo), 32'h7FFF);
        in_valid = 1'b0;
        onehot   = 16'h0020;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        onehot    = 16'h0010;
        step();
        onehot = 16'hFFFF;
        chk("bp_thermo0", 32'(thermo), 32'h000F);
        chk("bp_level0", 32'(level), 32'd4);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_ready%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_thermo%0d", c), 32'(thermo), 32'h000F);
            chk($sformatf("bp_oerr%0d", c), 32'(out_err), 32'd0);
            step();
        end
        out_ready = 1'b1;
        onehot    = 16'h0002;
        #1;
        chk("bp_ready_up", 32'(in_ready), 32'd1);
        step();
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_thermo", 32'(thermo), 32'h0001);
        chk("bp_next_level", 32'(level), 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // sticky clear race
        clr_err = 1'b1;
        step();
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        in_valid = 1'b1;
        onehot   = 16'h0000;
        step();
        chk("race_sticky", 32'(err_sticky), 32'd1);
`ifdef ONEHOT_ERR_CNT_EN
        chk("race_cnt", 32'(err_cnt), 32'd1);
`endif
        in_valid = 1'b0;
        step();
        chk("clr2_sticky", 32'(err_sticky), 32'd0);
        clr_err = 1'b0;

`ifdef ONEHOT_ERR_CNT_EN
        chk("cnt_cleared", 32'(err_cnt), 32'd0);
        in_valid = 1'b1;
        onehot   = 16'h0000;
        repeat (300) step();
        chk("cnt_sat", 32'(err_cnt), 32'hFF);
        clr_err = 1'b1;
        step();
        chk("cnt_clr_race", 32'(err_cnt), 32'd1);
        clr_err  = 1'b0;
        in_valid = 1'b0;
        step();
`endif

        // async reset mid-cycle with a held illegal word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        onehot    = 16'h0000;
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_sticky", 32'(err_sticky), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_thermo", 32'(thermo), 32'd0);
        chk("arst_err", 32'(out_err), 32'd0);
        chk("arst_sticky", 32'(err_sticky), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
`ifdef ONEHOT_ERR_CNT_EN
        chk("arst_cnt", 32'(err_cnt), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        chk("arst_rel_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
